// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared defaults and FSM encodings for the block RAM write/read path
package bram_pkg;

    localparam int BRAM_ADDR_W = 10;
    localparam int BRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - loadable incrementing counter that wraps modulo 2**W
module wrap_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Load takes priority so a rollback can never be lost to a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bram_wr_sequencer.sv
// rtl/bram_wr_sequencer.sv - frames a sample stream into circular port-A writes of the block RAM
module bram_wr_sequencer
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clka,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] wr_ptr
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              last_beat;
    logic              ptr_load;
    logic              frame_start;

    assign accept      = in_valid & in_ready;
    assign last_beat   = accept & (cnt == (len - CNT_ONE));
    assign frame_start = (state == ST_IDLE) & start & ~abort;
    assign busy        = (state == ST_FILL) | (state == ST_DONE);
    assign frame_done  = (state == ST_DONE);

    // State register.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stream handshake and pointer rollback/reload control.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ptr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_FILL;
                    ptr_load  = 1'b1;
                end
            end
            ST_FILL: begin
                in_ready = ~abort;
                if (abort) begin
                    state_nxt = ST_IDLE;
                    ptr_load  = 1'b1;
                end else if (last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working write pointer; reloaded from the committed pointer on start and abort.
    wrap_counter #(
        .W (ADDR_W)
    ) u_ptr (
        .clk      (clka),
        .rst_n    (reset_n),
        .load     (ptr_load),
        .load_val (wr_ptr),
        .inc      (accept),
        .count    (ptr)
    );

    // Frame length (zero encodes a full ring) and beat count for the current frame.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            len <= '0;
            cnt <= '0;
        end else if (frame_start) begin
            len <= {(frame_len == '0), frame_len};
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Registered RAM port-A drive: one write per accepted beat, one cycle later.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
        end else begin
            wea <= accept;
            if (accept) begin
                addra <= ptr;
                dina  <= in_data;
            end
        end
    end

    // Commit the end-of-frame pointer for the reader once the frame is complete.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
        end else if (state == ST_DONE) begin
            wr_ptr <= ptr;
        end
    end

endmodule

// File: tb/tb_bram_wr_sequencer.sv
// tb/tb_bram_wr_sequencer.sv - randomized scoreboard bench for bram_wr_sequencer
module tb_bram_wr_sequencer;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clka = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] frame_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] wr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is "start address + k" for k in 0..len-1.
    bit  m_in_frame  = 0;
    bit  m_done_cyc  = 0;
    bit  m_wea_exp   = 0;
    int  m_wr_ptr    = 0;
    int  m_start     = 0;
    int  m_len       = 0;
    int  m_cnt       = 0;

    logic [AW+DW-1:0] exp_wr[$];
    int               exp_done[$];
    bit               ptr_pend = 0;
    int               ptr_val  = 0;

    bram_wr_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clka       (clka),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .frame_len  (frame_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .busy       (busy),
        .frame_done (frame_done),
        .wr_ptr     (wr_ptr)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and commits whenever the DUT presents them.
    always @(negedge clka) begin
        if (reset_n) begin
            logic [AW+DW-1:0] e;
            chk("wea", int'(wea), int'(m_wea_exp));
            if (wea) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addra=%0d dina=0x%0h, none expected", addra, dina);
                end else begin
                    e = exp_wr.pop_front();
                    chk("addra", int'(addra), int'(e[AW+DW-1:DW]));
                    chk("dina", int'(dina), int'(e[DW-1:0]));
                end
            end
            chk("busy", int'(busy), int'(m_in_frame | m_done_cyc));
            if (ptr_pend) begin
                chk("wr_ptr_commit", int'(wr_ptr), ptr_val);
                ptr_pend = 0;
            end
            if (frame_done) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
                end else begin
                    ptr_val  = exp_done.pop_front();
                    ptr_pend = 1;
                end
            end
        end
    end

    // One clock of stimulus; the model advances on the same edge the DUT does.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit s, input bit a);
        in_valid = v;
        in_data  = d;
        start    = s;
        abort    = a;
        @(negedge clka);
        chk("in_ready", int'(in_ready), int'(m_in_frame && !a));
        @(posedge clka);
        m_wea_exp = 0;
        if (m_in_frame) begin
            if (a) begin
                m_in_frame = 0;
            end else if (v) begin
                exp_wr.push_back({AW'((m_start + m_cnt) % DEPTH), d});
                m_wea_exp = 1;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_wr_ptr = (m_start + m_len) % DEPTH;
                    exp_done.push_back(m_wr_ptr);
                    m_in_frame = 0;
                    m_done_cyc = 1;
                end
            end
        end else if (m_done_cyc) begin
            m_done_cyc = 0;
        end else if (s && !a) begin
            m_in_frame = 1;
            m_start    = m_wr_ptr;
            m_len      = (frame_len == 0) ? DEPTH : int'(frame_len);
            m_cnt      = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clka);
        #1;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        m_in_frame = 0;
        m_done_cyc = 0;
        m_wea_exp  = 0;
        m_wr_ptr   = 0;
        ptr_pend   = 0;
        exp_wr.delete();
        exp_done.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clka);
            chk("rst_wea", int'(wea), 0);
            chk("rst_addra", int'(addra), 0);
            chk("rst_dina", int'(dina), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_frame_done", int'(frame_done), 0);
            chk("rst_wr_ptr", int'(wr_ptr), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end
        @(posedge clka);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    // Start a frame and feed it until it completes or aborts, with random gaps,
    // spurious start pulses and a changing frame_len input after the start.
    task automatic run_frame(input int len, input int valid_pct, input int abort_at);
        int guard;
        frame_len = AW'(len);
        cyc(0, '0, 1, 0);
        guard = 0;
        while ((m_in_frame || m_done_cyc) && guard < 4000) begin
            bit v, s, a;
            v = ($urandom_range(99) < valid_pct);
            s = ($urandom_range(7) == 0);
            a = (abort_at >= 0) && m_in_frame && (m_cnt == abort_at);
            frame_len = AW'($urandom);
            cyc(v, DW'($urandom), s, a);
            guard++;
        end
        if (guard >= 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d cycles expected completion", guard);
        end
    endtask

    initial begin
        int bpat[6];
        int fill;
        bpat = '{1, 0, 1, 1, 0, 1};

        repeat (3) @(posedge clka);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Reset mid-stream, then stay idle with valid held high.
        frame_len = AW'(8);
        cyc(0, '0, 1, 0);
        cyc(1, 16'h1111, 0, 0);
        cyc(1, 16'h2222, 0, 0);
        do_reset(3);
        for (int i = 0; i < 3; i++) cyc(1, 16'h3333, 0, 0);
        chk("post_rst_wr_ptr", int'(wr_ptr), 0);

        // Four-word frame at address 0.
        frame_len = AW'(4);
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, DW'(16'hA000 + i), 0, 0);
        idle(3);
        chk("t2_wr_ptr", int'(wr_ptr), 4);

        // Backpressure gaps.
        frame_len = AW'(4);
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(bpat[i][0], DW'(16'hB000 + i), 0, 0);
        idle(3);
        chk("t4_wr_ptr", int'(wr_ptr), 8);

        // Abort after two of eight, then a single-word frame at the old pointer.
        run_frame(8, 100, 2);
        idle(2);
        chk("t5_wr_ptr_abort", int'(wr_ptr), 8);
        run_frame(1, 100, -1);
        idle(3);
        chk("t5_wr_ptr", int'(wr_ptr), 9);

        // Full ring frame; start & abort together in IDLE stays idle.
        run_frame(0, 100, -1);
        idle(3);
        chk("t6_wr_ptr", int'(wr_ptr), 9);
        frame_len = AW'(4);
        cyc(0, '0, 1, 1);
        cyc(1, 16'h5555, 0, 0);
        chk("t6_start_abort_busy", int'(busy), 0);

        // Bring the pointer to 1022 and write across the wrap.
        fill = (1022 - m_wr_ptr + DEPTH) % DEPTH;
        if (fill != 0) run_frame(fill, 80, -1);
        idle(3);
        chk("t3_pre_wr_ptr", int'(wr_ptr), 1022);
        run_frame(4, 100, -1);
        idle(3);
        chk("t3_wr_ptr", int'(wr_ptr), 2);

        // Random frames with occasional aborts.
        for (int f = 0; f < 20; f++) begin
            int l, ab;
            l  = $urandom_range(40, 1);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(l - 1)) : -1;
            run_frame(l, 60, ab);
            idle($urandom_range(3));
        end
        idle(4);
        chk("final_wr_ptr", int'(wr_ptr), m_wr_ptr);
        chk("exp_wr_empty", exp_wr.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
